// File: rtl/instr_fetch_pkg.sv
// Shared core definitions: instruction encoding and the fetch FSM state type.
package instr_fetch_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OP_W      = 2;

  // Instruction field bit positions (LSB of each field) for a 32-bit word
  localparam int unsigned OP_LSB    = 30;
  localparam int unsigned RD_LSB    = 25;
  localparam int unsigned RS1_LSB   = 20;
  localparam int unsigned RS2_LSB   = 15;
  localparam int unsigned PAD_W     = 15;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_2   = 2'b10
  } op_t;

  typedef struct packed {
    op_t                  op;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [PAD_W-1:0]     pad;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic instr_t make_instr(op_t op, logic [REG_IDX_W-1:0] rd,
                                        logic [REG_IDX_W-1:0] rs1,
                                        logic [REG_IDX_W-1:0] rs2);
    instr_t w;
    w.op  = op;
    w.rd  = rd;
    w.rs1 = rs1;
    w.rs2 = rs2;
    w.pad = '0;
    return w;
  endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: synchronous write, combinational read, contents survive reset.
module prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: loads a program, then issues len words to the core over a valid/ready link.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PROG_DEPTH  = 16,
  parameter int unsigned INSTR_WIDTH = 32,
  localparam int unsigned AW         = $clog2(PROG_DEPTH)
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [INSTR_WIDTH-1:0] i_wr_data,
  input  logic                   i_start,
  input  logic [AW:0]            i_len,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [AW-1:0]          o_pc
);

  state_t                 state, state_n;
  logic [INSTR_WIDTH-1:0] instr, instr_n;
  logic                   valid, valid_n;
  logic                   busy, busy_n;
  logic                   done, done_n;
  logic [AW-1:0]          pc, pc_n;
  logic [AW:0]            cnt, cnt_n;
  logic [AW:0]            len_q, len_n;

  logic [AW:0]            len_clamped;
  logic                   mem_we;
  logic [AW-1:0]          rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [INSTR_WIDTH-1:0] first_word;

  assign len_clamped = (i_len > (AW+1)'(PROG_DEPTH)) ? (AW+1)'(PROG_DEPTH) : i_len;
  assign mem_we      = i_wr_en && (state == ST_IDLE);
  assign rd_addr     = (state == ST_IDLE) ? '0 : AW'(pc + AW'(1));
  // A write to word 0 on the start edge must be visible to the first issued word
  assign first_word  = (mem_we && (i_wr_addr == '0)) ? i_wr_data : rd_data;

  prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (INSTR_WIDTH)
  ) u_prog_mem (
    .clk     (i_CLK),
    .wr_en   (mem_we),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State and output registers
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state <= ST_IDLE;
      instr <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pc    <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_n;
      instr <= instr_n;
      valid <= valid_n;
      busy  <= busy_n;
      done  <= done_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      len_q <= len_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    instr_n = instr;
    valid_n = valid;
    pc_n    = pc;
    cnt_n   = cnt;
    len_n   = len_q;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          len_n = len_clamped;
          cnt_n = '0;
          pc_n  = '0;
          if (len_clamped == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RUN;
            instr_n = first_word;
            valid_n = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (valid && i_ready) begin
          cnt_n = (AW+1)'(cnt + (AW+1)'(1));
          if (cnt_n == len_q) begin
            valid_n = 1'b0;
            state_n = ST_DONE;
          end else begin
            instr_n = rd_data;
            pc_n    = AW'(pc + AW'(1));
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    done_n = (state_n == ST_DONE);
    busy_n = (state_n != ST_IDLE);
  end

  assign o_instr = instr;
  assign o_valid = valid;
  assign o_busy  = busy;
  assign o_done  = done;
  assign o_pc    = pc;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PROG_DEPTH, default 16, SHALL set the number of 32-bit program-memory words; it is a power of two, at least 2.
REQ-002 Parameter INSTR_WIDTH, default 32, SHALL set the instruction word width; AW = clog2(PROG_DEPTH).
REQ-003 Ports SHALL be:
  i_CLK      in   1            sole clock; all logic on rising edge
  i_RST      in   1            asynchronous, active-high reset
  i_wr_en    in   1            program-load write strobe
  i_wr_addr  in   AW           program-load address
  i_wr_data  in   INSTR_WIDTH  program-load word {op[1:0], rd[4:0], rs1[4:0], rs2[4:0], 15'd0}
  i_start    in   1            start-issue request
  i_len      in   AW+1         number of instructions to issue; sampled with i_start
  o_instr    out  INSTR_WIDTH  instruction to the core (drives core i_instr)
  o_valid    out  1            o_instr valid (drives core i_valid)
  i_ready    in   1            core can accept (from core o_ready)
  o_busy     out  1            run in progress
  o_done     out  1            one-cycle pulse after the last instruction is accepted
  o_pc       out  AW           address of the word currently in, or next loaded into, o_instr

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-005 Transfer SHALL occur on a rising edge with o_valid=1 and i_ready=1.
REQ-006 In IDLE with i_wr_en=1: mem[i_wr_addr] <= i_wr_data at the edge; writes in RUN or DONE SHALL be ignored.
REQ-007 In IDLE, at an edge with i_start=1 and i_len>=1: go to RUN; load mem[0] into o_instr; o_valid=1; o_pc=0. Latency from start to valid is 1 cycle.
REQ-008 i_len values above PROG_DEPTH SHALL be clamped to PROG_DEPTH.
REQ-009 In IDLE, an edge with i_start=1 and i_len=0 SHALL go straight to DONE with o_valid staying 0.
REQ-010 In RUN, on a transfer that is not the last: load mem[o_pc+1] into o_instr; o_pc increments; o_valid stays 1. This gives one instruction per cycle with i_ready held high.
REQ-011 With o_valid=1 and i_ready=0: o_instr, o_pc and o_valid SHALL hold stable, with no skipped or duplicated words.
REQ-012 On the transfer of instruction number len: o_valid <= 0 and the FSM enters DONE.
REQ-013 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-014 o_busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-015 i_start SHALL be ignored outside IDLE.
REQ-016 i_wr_en together with i_start in IDLE: the write SHALL complete, and the run reads the updated contents.
REQ-017 o_pc SHALL never exceed PROG_DEPTH-1; there is no wrap within a run.

Reset
REQ-018 i_RST=1 SHALL immediately force FSM=IDLE, o_valid=0, o_done=0, o_busy=0, o_pc=0, o_instr=0 and the issue counter to 0, independent of i_CLK.
REQ-019 Reset in the middle of a run SHALL abandon the run with no o_done pulse.
REQ-020 Program memory SHALL NOT be cleared by reset.
REQ-021 The first edge after i_RST falls SHALL be a normal IDLE edge.

Structure
REQ-022 The shared core definitions header SHALL hold: opcode encodings (OP_ADD=2'b00, OP_SUB=2'b01, OP_2=2'b10), instruction field bit positions, and register-index width 5.
REQ-023 One sub-module prog_mem (synchronous write, combinational read, no reset) SHALL be used; the FSM, counters and output register live in instr_fetch.

Verification
REQ-024 Basic run: load mem[0..2] = 0x0611_0000, 0x4831_0000, 0x8A11_0000; start with len=3 and i_ready=1. Expect o_valid on 3 consecutive cycles carrying those words in order, o_done pulsing on the next cycle, then o_busy=0.
REQ-025 Backpressure: same program, with i_ready=0 for 4 cycles while 0x4831_0000 is presented. Expect o_instr held at 0x4831_0000 and o_pc=1 throughout, then 0x8A11_0000 one cycle after i_ready returns to 1; total of 3 transfers.
REQ-026 Zero length: i_start with i_len=0. Expect o_valid never asserted and o_done=1 exactly one cycle after start.
REQ-027 Clamp and ignore: i_len=20 issues exactly 16 words (mem[0..15]). During that run, i_wr_en to address 5 and a second i_start have no effect.
REQ-028 Reset mid-run: assert i_RST while o_pc=1 and i_ready=0. Expect o_valid=0 and o_busy=0 before the next edge and no o_done. A subsequent start with len=3 re-issues 0x0611_0000, 0x4831_0000, 0x8A11_0000.
